// File: rtl/ldtu_fc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ldtu_fc_sequencer
// Brief    : LDTU fast-command sequencer (flush, synch, BC0, ADC calibration).
// Revision : 1.0 - initial release
// ============================================================================
module ldtu_fc_sequencer #(
  parameter int FLUSH_LEN = 4,
  parameter int CAL_TMO   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_code,
  input  logic [31:0] synch_word,
  input  logic        calib_done,
  output logic        flush_b,
  output logic        synch,
  output logic [31:0] synch_pattern,
  output logic        Orbit,
  output logic        calib_start,
  output logic        calib_busy,
  output logic [7:0]  cmd_err_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FLUSH = 2'b01,
    ST_SYNCH = 2'b10,
    ST_CALIB = 2'b11
  } state_t;

  localparam logic [2:0] c_cmd_nop   = 3'b000;
  localparam logic [2:0] c_cmd_flush = 3'b001;
  localparam logic [2:0] c_cmd_start = 3'b010;
  localparam logic [2:0] c_cmd_stop  = 3'b011;
  localparam logic [2:0] c_cmd_bc0   = 3'b100;
  localparam logic [2:0] c_cmd_calib = 3'b101;

  localparam logic [7:0] c_flush_load = 8'(FLUSH_LEN);
  localparam logic [7:0] c_cal_load   = 8'(CAL_TMO);

  state_t     r_state;
  logic [7:0] r_flush_cnt;
  logic [7:0] r_cal_tmr;

  logic       w_do_flush;
  logic       w_do_start;
  logic       w_do_stop;
  logic       w_do_calib;
  logic       w_bc0;
  logic       w_reject;
  logic       w_cal_done;
  logic       w_cal_tmo;
  logic [8:0] w_err_sum;
  logic [7:0] w_err_next;

  assign state = r_state;

  always_comb begin
    w_do_flush = 1'b0;
    w_do_start = 1'b0;
    w_do_stop  = 1'b0;
    w_do_calib = 1'b0;
    w_bc0      = 1'b0;
    w_reject   = 1'b0;
    if (cmd_valid) begin
      case (cmd_code)
        c_cmd_nop: begin
        end
        c_cmd_flush: begin
          if (r_state == ST_IDLE || r_state == ST_SYNCH) w_do_flush = 1'b1;
          else                                             w_reject   = 1'b1;
        end
        c_cmd_start: begin
          if (r_state == ST_IDLE) w_do_start = 1'b1;
          else                    w_reject   = 1'b1;
        end
        c_cmd_stop: begin
          if (r_state == ST_SYNCH) w_do_stop = 1'b1;
          else                     w_reject  = 1'b1;
        end
        c_cmd_bc0: w_bc0 = 1'b1;
        c_cmd_calib: begin
          if (r_state == ST_IDLE) w_do_calib = 1'b1;
          else                    w_reject   = 1'b1;
        end
        default: w_reject = 1'b1;
      endcase
    end
  end

  // calib_done is ignored while calib_start is still high (first CALIB cycle)
  assign w_cal_done = (r_state == ST_CALIB) && !calib_start && calib_done;
  assign w_cal_tmo  = (r_state == ST_CALIB) && !w_cal_done && (r_cal_tmr == 8'd1);

  assign w_err_sum  = {1'b0, cmd_err_cnt} + 9'(w_reject) + 9'(w_cal_tmo);
  assign w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_flush_cnt   <= 8'd0;
      r_cal_tmr     <= 8'd0;
      flush_b       <= 1'b1;
      synch         <= 1'b0;
      synch_pattern <= 32'd0;
      Orbit         <= 1'b0;
      calib_start   <= 1'b0;
      calib_busy    <= 1'b0;
      cmd_err_cnt   <= 8'd0;
    end else begin
      Orbit       <= w_bc0;
      calib_start <= 1'b0;
      cmd_err_cnt <= w_err_next;
      case (r_state)
        ST_IDLE: begin
          if (w_do_flush) begin
            r_state     <= ST_FLUSH;
            flush_b     <= 1'b0;
            r_flush_cnt <= c_flush_load;
          end else if (w_do_start) begin
            r_state       <= ST_SYNCH;
            synch         <= 1'b1;
            synch_pattern <= synch_word;
          end else if (w_do_calib) begin
            r_state     <= ST_CALIB;
            calib_start <= 1'b1;
            calib_busy  <= 1'b1;
            r_cal_tmr   <= c_cal_load;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 8'd1) begin
            r_state     <= ST_IDLE;
            flush_b     <= 1'b1;
            r_flush_cnt <= 8'd0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 8'd1;
          end
        end
        ST_SYNCH: begin
          if (w_do_flush) begin
            r_state     <= ST_FLUSH;
            synch       <= 1'b0;
            flush_b     <= 1'b0;
            r_flush_cnt <= c_flush_load;
          end else if (w_do_stop) begin
            r_state <= ST_IDLE;
            synch   <= 1'b0;
          end
        end
        ST_CALIB: begin
          if (w_cal_done || w_cal_tmo) begin
            r_state    <= ST_IDLE;
            calib_busy <= 1'b0;
            r_cal_tmr  <= 8'd0;
          end else begin
            r_cal_tmr <= r_cal_tmr - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ldtu_fc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldtu_fc_sequencer
// Brief    : Scoreboard testbench for ldtu_fc_sequencer (FLUSH_LEN=4, CAL_TMO=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldtu_fc_sequencer;

  localparam int FLUSH_LEN = 4;
  localparam int CAL_TMO   = 8;

  localparam logic [2:0] c_nop   = 3'b000;
  localparam logic [2:0] c_flush = 3'b001;
  localparam logic [2:0] c_start = 3'b010;
  localparam logic [2:0] c_stop  = 3'b011;
  localparam logic [2:0] c_bc0   = 3'b100;
  localparam logic [2:0] c_calib = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [31:0] synch_word;
  logic        calib_done;
  logic        flush_b;
  logic        synch;
  logic [31:0] synch_pattern;
  logic        Orbit;
  logic        calib_start;
  logic        calib_busy;
  logic [7:0]  cmd_err_cnt;
  logic [1:0]  state;

  always #5 clk = ~clk;

  ldtu_fc_sequencer #(.FLUSH_LEN(FLUSH_LEN), .CAL_TMO(CAL_TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .synch_word    (synch_word),
    .calib_done    (calib_done),
    .flush_b       (flush_b),
    .synch         (synch),
    .synch_pattern (synch_pattern),
    .Orbit         (Orbit),
    .calib_start   (calib_start),
    .calib_busy    (calib_busy),
    .cmd_err_cnt   (cmd_err_cnt),
    .state         (state)
  );

  typedef struct packed {
    logic        flush_b;
    logic        synch;
    logic [31:0] pat;
    logic        orbit;
    logic        cstart;
    logic        cbusy;
    logic [7:0]  err;
    logic [1:0]  st;
  } snap_t;

  snap_t q[$];
  snap_t e;
  int    checks   = 0;
  int    failures = 0;

  function automatic snap_t sample();
    return {flush_b, synch, synch_pattern, Orbit, calib_start, calib_busy, cmd_err_cnt, state};
  endfunction

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] w, input logic d);
    @(negedge clk);
    cmd_valid  = v;
    cmd_code   = c;
    synch_word = w;
    calib_done = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t got, ex;
    rst = 1'b0; cmd_valid = 1'b0; cmd_code = c_nop; synch_word = '0; calib_done = 1'b0;
    #1 rst = 1'b1;
    e = '0; e.flush_b = 1'b1;
    q.push_back(e);
    #1;
    got = sample(); ex = q.pop_front(); checks++;
    if (got !== ex) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", got, ex);
    end
    @(negedge clk); rst = 1'b0;
    q.push_back(e);
    tick();
    got = sample(); ex = q.pop_front(); checks++;
    if (got !== ex) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", got, ex);
    end
  endtask

  task automatic test_flush();
    snap_t got, ex;
    for (int i = 0; i < 10; i++) begin
      drive(i == 0 || i == 4 || i == 5, c_flush, 32'h0, 1'b0);
      if (i == 4) e.err = e.err + 8'd1;  // FLUSH on the exit edge is still in FLUSH
      e.flush_b = !((i < FLUSH_LEN) || (i >= 5 && i < 5 + FLUSH_LEN));
      e.st      = e.flush_b ? 2'b00 : 2'b01;
      q.push_back(e);
      tick();
      got = sample(); ex = q.pop_front(); checks++;
      if (got !== ex) begin
        failures++; $display("FAIL flush cyc=%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_synch();
    snap_t got, ex;
    for (int i = 0; i < 12; i++) begin
      if (i == 0)       drive(1'b1, c_start, 32'h5A5A_A5A5, 1'b0);
      else if (i == 4)  drive(1'b1, c_start, 32'h1234_5678, 1'b0);
      else if (i == 10) drive(1'b1, c_stop,  32'hDEAD_BEEF, 1'b0);
      else              drive(1'b0, c_start, 32'hDEAD_BEEF, 1'b0);
      if (i == 0) e.pat = 32'h5A5A_A5A5;
      if (i == 4) e.err = e.err + 8'd1;
      e.synch = (i < 10);
      e.st    = (i < 10) ? 2'b10 : 2'b00;
      q.push_back(e);
      tick();
      got = sample(); ex = q.pop_front(); checks++;
      if (got !== ex) begin
        failures++; $display("FAIL synch cyc=%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_synch_flush();
    snap_t got, ex;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1'b1, c_start, 32'h0BAD_F00D, 1'b0);
      else if (i == 2) drive(1'b1, c_flush, 32'h0, 1'b0);
      else if (i == 3) drive(1'b1, c_stop,  32'h0, 1'b0);
      else if (i == 6) drive(1'b1, c_flush, 32'h0, 1'b0);
      else             drive(1'b0, c_nop,   32'h0, 1'b0);
      if (i == 0) e.pat = 32'h0BAD_F00D;
      if (i == 3 || i == 6) e.err = e.err + 8'd1;
      e.synch   = (i < 2);
      e.flush_b = !(i >= 2 && i < 2 + FLUSH_LEN);
      e.st      = (i < 2) ? 2'b10 : (!e.flush_b ? 2'b01 : 2'b00);
      q.push_back(e);
      tick();
      got = sample(); ex = q.pop_front(); checks++;
      if (got !== ex) begin
        failures++; $display("FAIL synch_flush cyc=%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_calib();
    snap_t got, ex;
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      drive(1'b1, c_calib, 32'h0, 1'b0);
      else if (i == 2) drive(1'b1, c_bc0,   32'h0, 1'b0);
      else if (i == 3) drive(1'b1, c_calib, 32'h0, 1'b0);
      else             drive(1'b0, c_nop,   32'h0, i == 5);
      if (i == 3) e.err = e.err + 8'd1;
      e.cstart = (i == 0);
      e.cbusy  = (i < 5);
      e.orbit  = (i == 2);
      e.st     = (i < 5) ? 2'b11 : 2'b00;
      q.push_back(e);
      tick();
      got = sample(); ex = q.pop_front(); checks++;
      if (got !== ex) begin
        failures++; $display("FAIL calib cyc=%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_calib_timeout();
    snap_t got, ex;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < CAL_TMO + 2; i++) begin
        if (i == 0)                      drive(1'b1, c_calib, 32'h0, 1'b0);
        else if (i == CAL_TMO && rep == 0) drive(1'b1, 3'b110, 32'h0, 1'b0);
        else                             drive(1'b0, c_nop,   32'h0, 1'b0);
        if (i == CAL_TMO) e.err = e.err + ((rep == 0) ? 8'd2 : 8'd1);
        e.cstart = (i == 0);
        e.cbusy  = (i < CAL_TMO);
        e.orbit  = 1'b0;
        e.st     = (i < CAL_TMO) ? 2'b11 : 2'b00;
        q.push_back(e);
        tick();
        got = sample(); ex = q.pop_front(); checks++;
        if (got !== ex) begin
          failures++; $display("FAIL calib_tmo rep=%0d cyc=%0d got=%h exp=%h", rep, i, got, ex);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t got, ex;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1:    drive(1'b1, c_bc0,   32'h0, 1'b0);
        2:       drive(1'b1, c_stop,  32'h0, 1'b0);
        3:       drive(1'b1, 3'b111,  32'h0, 1'b0);
        4:       drive(1'b1, c_nop,   32'h0, 1'b0);
        5:       drive(1'b0, c_flush, 32'h0, 1'b0);
        6:       drive(1'b1, 3'b110,  32'h0, 1'b0);
        default: drive(1'b0, c_nop,   32'h0, 1'b0);
      endcase
      if (i == 2 || i == 3 || i == 6) e.err = e.err + 8'd1;
      e.orbit = (i < 2);
      e.st    = 2'b00;
      q.push_back(e);
      tick();
      got = sample(); ex = q.pop_front(); checks++;
      if (got !== ex) begin
        failures++; $display("FAIL b2b_err cyc=%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_saturate();
    snap_t got, ex;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, (i % 2 == 0) ? 3'b110 : 3'b111, 32'h0, 1'b0);
      if (e.err != 8'hFF) e.err = e.err + 8'd1;
      e.orbit = 1'b0;
      q.push_back(e);
      tick();
      got = sample(); ex = q.pop_front(); checks++;
      if (got !== ex) begin
        failures++; $display("FAIL saturate cyc=%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_reset_abort();
    snap_t       got, ex;
    logic [2:0]  code;
    for (int s = 0; s < 3; s++) begin
      code = (s == 0) ? c_flush : (s == 1) ? c_start : c_calib;
      for (int ph = 0; ph < 3; ph++) begin
        if (ph == 0) begin
          drive(1'b1, code, 32'hC0FF_EE00 + s, 1'b0);
          e.flush_b = (s != 0);
          e.synch   = (s == 1);
          if (s == 1) e.pat = 32'hC0FF_EE01;
          e.cstart  = (s == 2);
          e.cbusy   = (s == 2);
          e.orbit   = 1'b0;
          e.st      = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : 2'b11;
          q.push_back(e);
          tick();
        end else if (ph == 1) begin
          drive(1'b0, c_nop, 32'h0, 1'b0);
          #2 rst = 1'b1;
          e = '0; e.flush_b = 1'b1;
          q.push_back(e);
          #1;
        end else begin
          @(negedge clk);
          rst = 1'b0;
          q.push_back(e);
          tick();
        end
        got = sample(); ex = q.pop_front(); checks++;
        if (got !== ex) begin
          failures++; $display("FAIL rst_abort s=%0d ph=%0d got=%h exp=%h", s, ph, got, ex);
        end
      end
    end
  endtask

  task automatic test_first_cmd();
    snap_t got, ex;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b1; cmd_code = c_bc0;
    e = '0; e.flush_b = 1'b1; e.orbit = 1'b1;
    q.push_back(e);
    tick();
    got = sample(); ex = q.pop_front(); checks++;
    if (got !== ex) begin
      failures++; $display("FAIL first_cmd got=%h exp=%h", got, ex);
    end
    drive(1'b0, c_nop, 32'h0, 1'b0);
    e.orbit = 1'b0;
    q.push_back(e);
    tick();
    got = sample(); ex = q.pop_front(); checks++;
    if (got !== ex) begin
      failures++; $display("FAIL first_cmd_pulse got=%h exp=%h", got, ex);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_flush();
    test_synch();
    test_synch_flush();
    test_calib();
    test_calib_timeout();
    test_back_to_back();
    test_saturate();
    test_reset_abort();
    test_first_cmd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
